// File: rtl/load_unit_ctrl.sv
// load_unit_ctrl: sequencer for byte/halfword/word loads from a word-wide memory.
//
// A request is accepted in IDLE. Misaligned or illegal requests finish at once
// with an error. Legal requests issue one aligned word read and wait for
// mem_ready. The addressed byte or halfword is then selected and sign- or
// zero-extended.
//
// Optional feature: define LOAD_UNIT_TIMEOUT_EN to abort a read that sees no
// mem_ready within TIMEOUT_CYCLES WAIT cycles. The abort reports err=1 and
// load_data=0.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   start      - load request, sampled only in IDLE
//   op[2:0]    - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes illegal
//   addr[31:0] - byte address of the load
//   mem_rdata  - memory read word, valid with mem_ready
//   mem_ready  - memory response strobe, honoured only in WAIT
//   mem_req    - read request, held from REQ through WAIT
//   mem_addr   - word-aligned address of the current or last request
//   busy       - controller not IDLE
//   done       - one-cycle completion pulse
//   err        - fault flag, valid with done and held until the next done
//   load_data  - extended load result, held until the next done
module load_unit_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_LB  = 3'b000;
    localparam logic [OP_W-1:0] OP_LH  = 3'b001;
    localparam logic [OP_W-1:0] OP_LW  = 3'b010;
    localparam logic [OP_W-1:0] OP_LBU = 3'b100;
    localparam logic [OP_W-1:0] OP_LHU = 3'b101;

    // Reject out-of-range configuration at elaboration time.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("load_unit_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OP_W-1:0]   op_q;
    logic [1:0]        off_q;
    logic              set_result;
    logic [DATA_W-1:0] result_d;
    logic              err_d;

    // Fault: illegal opcode, odd halfword address or non-word-aligned word.
    function automatic logic is_fault(input logic [OP_W-1:0] f_op,
                                      input logic [1:0]      f_off);
        logic f;
        f = 1'b1;
        case (f_op)
            OP_LB, OP_LBU: f = 1'b0;
            OP_LH, OP_LHU: f = f_off[0];
            OP_LW:         f = (f_off != 2'b00);
            default:       f = 1'b1;
        endcase
        return f;
    endfunction

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [DATA_W-1:0] extract(input logic [OP_W-1:0]   x_op,
                                                  input logic [1:0]        x_off,
                                                  input logic [DATA_W-1:0] x_word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (x_off)
            2'd0:    b = x_word[7:0];
            2'd1:    b = x_word[15:8];
            2'd2:    b = x_word[23:16];
            default: b = x_word[31:24];
        endcase
        h = x_off[1] ? x_word[31:16] : x_word[15:0];
        case (x_op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LW:   r = x_word;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int unsigned TMO_W = 8;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit_c;

    // Last permitted WAIT cycle; mem_ready in that same cycle still wins.
    assign tmo_hit_c = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter, cleared on WAIT entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_d == S_WAIT && state_q != S_WAIT) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`endif

    // Next-state and result selection.
    always_comb begin
        state_d    = state_q;
        set_result = 1'b0;
        result_d   = '0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_fault(op, addr[1:0])) begin
                        state_d    = S_DONE;
                        set_result = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d    = S_DONE;
                    set_result = 1'b1;
                    result_d   = extract(op_q, off_q, mem_rdata);
`ifdef LOAD_UNIT_TIMEOUT_EN
                end else if (tmo_hit_c) begin
                    state_d    = S_DONE;
                    set_result = 1'b1;
                    err_d      = 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            off_q     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= '0;
        end else begin
            state_q <= state_d;
            mem_req <= (state_d == S_REQ) || (state_d == S_WAIT);
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
            if (state_q == S_IDLE && start) begin
                op_q     <= op;
                off_q    <= addr[1:0];
                mem_addr <= {addr[31:2], 2'b00};
            end
            if (set_result) begin
                load_data <= result_d;
                err       <= err_d;
            end
        end
    end

endmodule
